// File: rtl/duck_mover.sv
`default_nettype none
// ============================================================================
// Module   : duck_mover
// Purpose  : Motion controller for the duck sprite. It spawns the duck at a
//            pseudo-random position, bounces it around the screen once per
//            frame, and handles being shot (pause, then fall to the ground)
//            or escaping off the top after a flight timeout. After either
//            outcome it waits a fixed number of frames and respawns.
// Ports    : clk          - pixel clock
//            rst          - asynchronous active-high reset
//            new_frame    - one-cycle pulse per video frame
//            hit          - qualified shot on the duck
//            target_x/y   - duck top-left corner (registered)
//            duck_visible - duck is on screen (FLY, HIT_PAUSE, FALL, ESCAPE)
//            duck_hit     - duck has been shot (HIT_PAUSE, FALL)
//            killed       - one-cycle pulse when the duck lands
//            escaped      - one-cycle pulse when the duck leaves the top
// Revision : 1.0 - initial release
// ============================================================================
module duck_mover #(
  parameter int          HOR_PIXELS     = 1024,
  parameter int          GROUND_Y       = 600,
  parameter int          TARGET_WIDTH   = 64,
  parameter int          TARGET_HEIGHT  = 48,
  parameter int          SPEED_X        = 4,
  parameter int          SPEED_Y        = 3,
  parameter int          FALL_SPEED     = 8,
  parameter int          FLY_FRAMES     = 600,
  parameter int          HIT_FRAMES     = 30,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       hit,
  output logic [9:0] target_x,
  output logic [9:0] target_y,
  output logic       duck_visible,
  output logic       duck_hit,
  output logic       killed,
  output logic       escaped
);

  localparam logic [9:0] c_MAX_X          = 10'(HOR_PIXELS - TARGET_WIDTH);
  localparam logic [9:0] c_MAX_Y          = 10'(GROUND_Y - TARGET_HEIGHT);
  localparam logic [9:0] c_RESET_X        = 10'((HOR_PIXELS - TARGET_WIDTH) / 2);
  localparam logic [9:0] c_GROUND         = 10'(GROUND_Y);
  localparam logic [9:0] c_SPEED_X        = 10'(SPEED_X);
  localparam logic [9:0] c_SPEED_Y        = 10'(SPEED_Y);
  localparam logic [9:0] c_FALL_SPEED     = 10'(FALL_SPEED);
  localparam logic [9:0] c_FLY_FRAMES     = 10'(FLY_FRAMES);
  localparam logic [9:0] c_HIT_FRAMES     = 10'(HIT_FRAMES);
  localparam logic [9:0] c_RESPAWN_FRAMES = 10'(RESPAWN_FRAMES);
  localparam logic [9:0] c_SPAWN_X_BASE   = 10'd128;
  localparam logic [9:0] c_CNT_MAX        = 10'h3FF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLY       = 3'd1,
    S_HIT_PAUSE = 3'd2,
    S_FALL      = 3'd3,
    S_ESCAPE    = 3'd4,
    S_WAIT      = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  w_x_next;
  logic [9:0]  w_y_next;
  logic        r_dir_right;
  logic        r_dir_up;
  logic        w_dir_right_next;
  logic        w_dir_up_next;
  logic [9:0]  r_cnt;
  logic [9:0]  w_cnt_next;
  logic [9:0]  w_cnt_inc;
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;
  logic        r_visible;
  logic        r_hit_flag;
  logic        r_killed;
  logic        r_escaped;
  logic        w_killed_next;
  logic        w_escaped_next;
  logic        w_visible_next;
  logic        w_hit_flag_next;
  logic        w_spawn;
  // One extra bit so the boundary compares cannot wrap.
  logic [10:0] w_x_add;
  logic [10:0] w_y_add;
  logic [10:0] w_y_fall;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Frame counters saturate rather than wrap.
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 10'd1;

  assign w_x_add  = {1'b0, r_x} + {1'b0, c_SPEED_X};
  assign w_y_add  = {1'b0, r_y} + {1'b0, c_SPEED_Y};
  assign w_y_fall = {1'b0, r_y} + {1'b0, c_FALL_SPEED};

  always_comb begin
    w_state_next     = r_state;
    w_x_next         = r_x;
    w_y_next         = r_y;
    w_dir_right_next = r_dir_right;
    w_dir_up_next    = r_dir_up;
    w_cnt_next       = r_cnt;
    w_killed_next    = 1'b0;
    w_escaped_next   = 1'b0;
    w_spawn          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (new_frame) begin
          w_spawn = 1'b1;
        end
      end

      S_FLY: begin
        // A shot takes priority over movement and over the flight timeout.
        if (hit) begin
          w_state_next = S_HIT_PAUSE;
          w_cnt_next   = 10'd0;
        end else if (new_frame) begin
          if (r_dir_right) begin
            if (w_x_add >= {1'b0, c_MAX_X}) begin
              w_x_next         = c_MAX_X;
              w_dir_right_next = 1'b0;
            end else begin
              w_x_next = w_x_add[9:0];
            end
          end else begin
            if (r_x < c_SPEED_X) begin
              w_x_next         = 10'd0;
              w_dir_right_next = 1'b1;
            end else begin
              w_x_next = r_x - c_SPEED_X;
            end
          end

          if (r_dir_up) begin
            if (r_y < c_SPEED_Y) begin
              w_y_next      = 10'd0;
              w_dir_up_next = 1'b0;
            end else begin
              w_y_next = r_y - c_SPEED_Y;
            end
          end else begin
            if (w_y_add >= {1'b0, c_MAX_Y}) begin
              w_y_next      = c_MAX_Y;
              w_dir_up_next = 1'b1;
            end else begin
              w_y_next = w_y_add[9:0];
            end
          end

          if (w_cnt_inc == c_FLY_FRAMES) begin
            w_state_next = S_ESCAPE;
            w_cnt_next   = 10'd0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end

      S_HIT_PAUSE: begin
        if (new_frame) begin
          if (w_cnt_inc == c_HIT_FRAMES) begin
            w_state_next = S_FALL;
            w_cnt_next   = 10'd0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end

      S_FALL: begin
        if (new_frame) begin
          if (w_y_fall >= {1'b0, c_GROUND}) begin
            w_y_next      = c_GROUND;
            w_killed_next = 1'b1;
            w_state_next  = S_WAIT;
            w_cnt_next    = 10'd0;
          end else begin
            w_y_next = w_y_fall[9:0];
          end
        end
      end

      S_ESCAPE: begin
        if (new_frame) begin
          if (r_y < c_SPEED_Y) begin
            w_y_next       = 10'd0;
            w_escaped_next = 1'b1;
            w_state_next   = S_WAIT;
            w_cnt_next     = 10'd0;
          end else begin
            w_y_next = r_y - c_SPEED_Y;
          end
        end
      end

      S_WAIT: begin
        if (new_frame) begin
          if (w_cnt_inc == c_RESPAWN_FRAMES) begin
            w_spawn = 1'b1;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Spawn: x in 128..639 from the low LFSR bits, start on the ground
    // strip heading up, horizontal direction from the LFSR MSB.
    if (w_spawn) begin
      w_state_next     = S_FLY;
      w_x_next         = c_SPAWN_X_BASE + {1'b0, r_lfsr[8:0]};
      w_y_next         = c_MAX_Y;
      w_dir_right_next = r_lfsr[15];
      w_dir_up_next    = 1'b1;
      w_cnt_next       = 10'd0;
    end

    w_visible_next  = (w_state_next == S_FLY) || (w_state_next == S_HIT_PAUSE) ||
                      (w_state_next == S_FALL) || (w_state_next == S_ESCAPE);
    w_hit_flag_next = (w_state_next == S_HIT_PAUSE) || (w_state_next == S_FALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= c_RESET_X;
      r_y         <= c_MAX_Y;
      r_dir_right <= 1'b0;
      r_dir_up    <= 1'b1;
      r_cnt       <= 10'd0;
      r_lfsr      <= SEED;
      r_visible   <= 1'b0;
      r_hit_flag  <= 1'b0;
      r_killed    <= 1'b0;
      r_escaped   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_dir_right <= w_dir_right_next;
      r_dir_up    <= w_dir_up_next;
      r_cnt       <= w_cnt_next;
      r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
      r_visible   <= w_visible_next;
      r_hit_flag  <= w_hit_flag_next;
      r_killed    <= w_killed_next;
      r_escaped   <= w_escaped_next;
    end
  end

  assign target_x     = r_x;
  assign target_y     = r_y;
  assign duck_visible = r_visible;
  assign duck_hit     = r_hit_flag;
  assign killed       = r_killed;
  assign escaped      = r_escaped;

endmodule
`default_nettype wire

// File: tb/tb_duck_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_duck_mover
// Purpose  : Self-checking bench for duck_mover. A behavioural model of the
//            duck's life cycle predicts every registered output; predictions
//            are queued by the stimulus and compared by an independent
//            monitor one cycle later. Pulse totals and the asynchronous
//            reset response are also checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_duck_mover;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_frame;
  logic       hit;
  logic [9:0] target_x;
  logic [9:0] target_y;
  logic       duck_visible;
  logic       duck_hit;
  logic       killed;
  logic       escaped;

  duck_mover dut (
    .clk          (clk),
    .rst          (rst),
    .new_frame    (new_frame),
    .hit          (hit),
    .target_x     (target_x),
    .target_y     (target_y),
    .duck_visible (duck_visible),
    .duck_hit     (duck_hit),
    .killed       (killed),
    .escaped      (escaped)
  );

  always #5 clk = ~clk;

  // Screen geometry and timing for the default parameter set.
  localparam int MAX_X   = 1024 - 64;
  localparam int MAX_Y   = 600 - 48;
  localparam int GROUND  = 600;
  localparam int SPD_X   = 4;
  localparam int SPD_Y   = 3;
  localparam int FALL    = 8;
  localparam int FLY_N   = 600;
  localparam int HIT_N   = 30;
  localparam int RESP_N  = 60;

  localparam int P_IDLE = 0, P_FLY = 1, P_PAUSE = 2, P_FALL = 3, P_ESCAPE = 4, P_WAIT = 5;

  // Behavioural model state: what the DUT outputs after the next edge.
  int          m_phase;
  int          m_x;
  int          m_y;
  int          m_frames;
  bit          m_right;
  bit          m_up;
  bit          m_killed;
  bit          m_escaped;
  logic [15:0] m_lfsr;
  int          m_kills   = 0;
  int          m_escapes = 0;

  int dut_kills   = 0;
  int dut_escapes = 0;
  int n_checks    = 0;
  int n_errors    = 0;

  logic [23:0] exp_q[$];

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_x       = 480;
    m_y       = MAX_Y;
    m_frames  = 0;
    m_right   = 1'b0;
    m_up      = 1'b1;
    m_killed  = 1'b0;
    m_escaped = 1'b0;
    m_lfsr    = 16'hACE1;
  endtask

  task automatic model_spawn(input logic [15:0] l);
    m_x      = 128 + int'(l[8:0]);
    m_y      = MAX_Y;
    m_right  = l[15];
    m_up     = 1'b1;
    m_frames = 0;
    m_phase  = P_FLY;
  endtask

  // One clock edge of the duck's life.
  task automatic model_edge(input logic nf, input logic h, input logic r);
    logic [15:0] l;
    if (r) begin
      model_reset();
    end else begin
      l         = m_lfsr;
      m_lfsr    = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      m_killed  = 1'b0;
      m_escaped = 1'b0;
      case (m_phase)
        P_IDLE: if (nf) model_spawn(l);
        P_FLY: begin
          if (h) begin
            m_phase  = P_PAUSE;
            m_frames = 0;
          end else if (nf) begin
            if (m_right) begin
              if (m_x + SPD_X >= MAX_X) begin m_x = MAX_X; m_right = 1'b0; end
              else m_x = m_x + SPD_X;
            end else begin
              if (m_x < SPD_X) begin m_x = 0; m_right = 1'b1; end
              else m_x = m_x - SPD_X;
            end
            if (m_up) begin
              if (m_y < SPD_Y) begin m_y = 0; m_up = 1'b0; end
              else m_y = m_y - SPD_Y;
            end else begin
              if (m_y + SPD_Y >= MAX_Y) begin m_y = MAX_Y; m_up = 1'b1; end
              else m_y = m_y + SPD_Y;
            end
            m_frames++;
            if (m_frames == FLY_N) begin m_phase = P_ESCAPE; m_frames = 0; end
          end
        end
        P_PAUSE: if (nf) begin
          m_frames++;
          if (m_frames == HIT_N) begin m_phase = P_FALL; m_frames = 0; end
        end
        P_FALL: if (nf) begin
          if (m_y + FALL >= GROUND) begin
            m_y = GROUND; m_killed = 1'b1; m_kills++; m_phase = P_WAIT; m_frames = 0;
          end else m_y = m_y + FALL;
        end
        P_ESCAPE: if (nf) begin
          if (m_y < SPD_Y) begin
            m_y = 0; m_escaped = 1'b1; m_escapes++; m_phase = P_WAIT; m_frames = 0;
          end else m_y = m_y - SPD_Y;
        end
        P_WAIT: if (nf) begin
          m_frames++;
          if (m_frames == RESP_N) model_spawn(l);
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [23:0] model_pack();
    logic vis;
    logic hf;
    vis = (m_phase == P_FLY) || (m_phase == P_PAUSE) || (m_phase == P_FALL) || (m_phase == P_ESCAPE);
    hf  = (m_phase == P_PAUSE) || (m_phase == P_FALL);
    return {10'(m_x), 10'(m_y), vis, hf, m_killed, m_escaped};
  endfunction

  // Called at a falling edge: drive inputs, predict the next edge, queue it.
  task automatic step(input logic nf, input logic h, input logic r);
    logic was_rst;
    was_rst   = rst;
    new_frame = nf;
    hit       = h;
    rst       = r;
    if (r && !was_rst) begin
      #1;
      n_checks++;
      if ({target_x, target_y, duck_visible, duck_hit, killed, escaped} !==
          {10'd480, 10'd552, 4'b0000}) begin
        n_errors++;
        $display("FAIL async_reset: actual x=%0d y=%0d vis=%0b hit=%0b killed=%0b esc=%0b, required x=480 y=552 flags=0",
                 target_x, target_y, duck_visible, duck_hit, killed, escaped);
      end
    end
    model_edge(nf, h, r);
    exp_q.push_back(model_pack());
    @(negedge clk);
  endtask

  function automatic logic rand_nf();
    return ($urandom_range(0, 2) == 0);
  endfunction

  // hit_mode 0: never hit; 1: random hits only outside FLY; 2: rare hits anywhere.
  function automatic logic rand_hit(input int hit_mode);
    if (hit_mode == 1) return (m_phase != P_FLY) && ($urandom_range(0, 3) == 0);
    if (hit_mode == 2) return ($urandom_range(0, 149) == 0);
    return 1'b0;
  endfunction

  task automatic run_until(input int target, input int budget, input int hit_mode, input string tag);
    int n;
    n = 0;
    while (m_phase != target && n < budget) begin
      step(rand_nf(), rand_hit(hit_mode), 1'b0);
      n++;
    end
    if (m_phase != target) begin
      n_errors++;
      $display("FAIL %s: phase %0d after %0d cycles, required %0d", tag, m_phase, n, target);
    end
  endtask

  task automatic fly_frames(input int k, input string tag);
    int n;
    n = 0;
    while (m_phase == P_FLY && m_frames < k && n < 20000) begin
      step(rand_nf(), 1'b0, 1'b0);
      n++;
    end
    if (m_phase != P_FLY || m_frames != k) begin
      n_errors++;
      $display("FAIL %s: phase %0d frames %0d, required phase 1 frames %0d", tag, m_phase, m_frames, k);
    end
  endtask

  // Monitor: compare every registered output just after each rising edge.
  initial begin
    logic [23:0] exp;
    logic [23:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (killed)  dut_kills++;
      if (escaped) dut_escapes++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {target_x, target_y, duck_visible, duck_hit, killed, escaped};
        n_checks++;
        if (act !== exp) begin
          n_errors++;
          $display("FAIL outputs @%0t: actual x=%0d y=%0d vis=%0b hit=%0b kil=%0b esc=%0b, required x=%0d y=%0d vis=%0b hit=%0b kil=%0b esc=%0b",
                   $time, act[23:14], act[13:4], act[3], act[2], act[1], act[0],
                   exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    new_frame = 1'b0;
    hit       = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held, then idle with no frames (and an ignored hit).
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    run_until(P_FLY, 100, 1, "first_spawn");

    // Full flight without a hit: timeout, escape, respawn.
    run_until(P_ESCAPE, 4000, 1, "to_escape");
    run_until(P_WAIT, 2000, 1, "escape_done");
    run_until(P_FLY, 600, 1, "respawn_after_escape");

    // Shot together with a frame pulse, then pause, fall, respawn.
    fly_frames($urandom_range(20, 200), "kill_flight");
    step(1'b1, 1'b1, 1'b0);
    run_until(P_FALL, 600, 1, "pause_done");
    run_until(P_WAIT, 1000, 1, "fall_done");
    run_until(P_FLY, 600, 1, "respawn_after_kill");

    // Shot on the very frame the flight would time out.
    fly_frames(FLY_N - 1, "timeout_flight");
    step(1'b1, 1'b1, 1'b0);
    run_until(P_WAIT, 1500, 1, "timeout_hit_done");
    run_until(P_FLY, 600, 1, "respawn_after_timeout_hit");

    // Reset in the middle of a fall: no killed pulse, back to IDLE.
    fly_frames($urandom_range(5, 50), "reset_flight");
    step(1'b1, 1'b1, 1'b0);
    run_until(P_FALL, 600, 0, "reset_pause_done");
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    run_until(P_FLY, 100, 0, "spawn_after_reset");

    // Free-running random mix.
    repeat (4000) step(rand_nf(), rand_hit(2), 1'b0);

    step(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d predictions never compared, required 0", exp_q.size());
    end
    n_checks++;
    if (dut_kills != m_kills) begin
      n_errors++;
      $display("FAIL kill_count: actual %0d, required %0d", dut_kills, m_kills);
    end
    n_checks++;
    if (dut_escapes != m_escapes) begin
      n_errors++;
      $display("FAIL escape_count: actual %0d, required %0d", dut_escapes, m_escapes);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
